// File: rtl/simd_pkg.sv
// Shared types and helpers for the vector memory sequencer.
// Holds the FSM state enum, word/lane sizing and the lane-slice helper.
package simd_pkg;

  localparam int LANES_DEF = 8;
  localparam int LANES_MAX = 16;
  localparam int WORD_W    = 32;

  typedef enum logic [2:0] {
    IDLE,
    SRD,
    VST,
    VLD,
    VDRAIN
  } vmem_state_t;

  // Picks word idx out of a vector zero-extended to LANES_MAX lanes.
  function automatic logic [WORD_W-1:0] lane_slice(
    input logic [LANES_MAX*WORD_W-1:0] vec,
    input logic [3:0]                  idx
  );
    logic [8:0] lo;
    lo = {idx, 5'b00000};
    return vec[lo +: WORD_W];
  endfunction

endpackage

// File: rtl/vmem_lane_reg.sv
// LANES x 32 capture register: one write enable per lane, a shared write word,
// synchronous clear of all lanes and asynchronous active-low reset.
module vmem_lane_reg
  import simd_pkg::*;
#(
  parameter int LANES = LANES_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clr_i,
  input  logic [LANES-1:0]              we_i,
  input  logic [WORD_W-1:0]             wdata_i,
  output logic [LANES-1:0][WORD_W-1:0]  q_o
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [WORD_W-1:0] lane_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset)        lane_q <= '0;
      else if (clr_i)    lane_q <= '0;
      else if (we_i[i])  lane_q <= wdata_i;
    end

    assign q_o[i] = lane_q;
  end

endmodule

// File: rtl/vmem_sequencer.sv
// M-stage sequencer sharing one 32-bit memory port between scalar accesses and
// LANES-beat vector loads/stores; holds stallM until the access completes.
module vmem_sequencer
  import simd_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int AW    = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_req,
  input  logic                    s_we,
  input  logic [AW-1:0]           s_addr,
  input  logic [WORD_W-1:0]       s_wdata,
  output logic [WORD_W-1:0]       s_rdata,
  output logic                    s_ready,
  input  logic                    v_req,
  input  logic                    v_we,
  input  logic [AW-1:0]           v_base,
  input  logic [WORD_W*LANES-1:0] v_wdata,
  output logic [WORD_W*LANES-1:0] v_rdata,
  output logic                    v_done,
  output logic                    stallM,
  output logic [AW-1:0]           mem_addr,
  output logic                    mem_we,
  output logic [WORD_W-1:0]       mem_wdata,
  input  logic [WORD_W-1:0]       mem_rdata
);

  localparam int BW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [BW-1:0] LAST = BW'(LANES - 1);

  vmem_state_t state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [AW-1:0] base_q;
  logic [LANES-1:0][WORD_W-1:0] wdata_q, stage, load_vec, rdata_q, vout;
  logic [LANES_MAX*WORD_W-1:0] wdata_ext;
  logic [AW-1:0] beat_addr;
  logic [LANES-1:0] cap_we;
  logic accept, stage_clr, rdata_ld, last_beat;
  logic mem_we_c, s_ready_c, v_done_c, stall_c;
  logic [AW-1:0] mem_addr_c;
  logic [WORD_W-1:0] mem_wdata_c, s_rdata_c;
  logic unused_addr_bits;

  assign unused_addr_bits = ^{s_addr[1:0], v_base[1:0]};

  // Burst address wraps modulo 2^AW through plain AW-bit addition.
  assign beat_addr = base_q + {{(AW-BW-2){1'b0}}, beat_q, 2'b00};
  assign last_beat = (beat_q == LAST);

  always_comb begin
    wdata_ext = '0;
    wdata_ext[LANES*WORD_W-1:0] = wdata_q;
  end

  // Final lane comes straight off the memory port in VDRAIN.
  always_comb begin
    load_vec = stage;
    load_vec[LANES-1] = mem_rdata;
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    accept      = 1'b0;
    stage_clr   = 1'b0;
    rdata_ld    = 1'b0;
    cap_we      = '0;
    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    s_ready_c   = 1'b0;
    s_rdata_c   = '0;
    v_done_c    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (v_req) begin
          accept    = 1'b1;
          beat_d    = '0;
          stage_clr = !v_we;
          state_d   = v_we ? VST : VLD;
        end else if (s_req) begin
          mem_addr_c = {s_addr[AW-1:2], 2'b00};
          if (s_we) begin
            mem_we_c    = 1'b1;
            mem_wdata_c = s_wdata;
            s_ready_c   = 1'b1;
          end else begin
            state_d = SRD;
          end
        end
      end
      SRD: begin
        s_ready_c = 1'b1;
        s_rdata_c = mem_rdata;
        state_d   = IDLE;
      end
      VST: begin
        mem_we_c    = 1'b1;
        mem_addr_c  = beat_addr;
        mem_wdata_c = lane_slice(wdata_ext, 4'(beat_q));
        if (last_beat) begin
          v_done_c = 1'b1;
          beat_d   = '0;
          state_d  = IDLE;
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      VLD: begin
        mem_addr_c = beat_addr;
        // Read data lags the address by one cycle, so it belongs to lane beat-1.
        if (beat_q != '0) cap_we = LANES'(1) << (beat_q - BW'(1));
        if (last_beat) begin
          beat_d  = '0;
          state_d = VDRAIN;
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      VDRAIN: begin
        v_done_c = 1'b1;
        rdata_ld = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      base_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (accept) begin
        base_q  <= {v_base[AW-1:2], 2'b00};
        wdata_q <= v_wdata;
      end
      if (rdata_ld) rdata_q <= load_vec;
    end
  end

  vmem_lane_reg #(.LANES(LANES)) u_stage (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (stage_clr),
    .we_i    (cap_we),
    .wdata_i (mem_rdata),
    .q_o     (stage)
  );

  assign stall_c = (state_q != IDLE)
                 | (v_req & (state_q == IDLE))
                 | (s_req & !s_we & (state_q == IDLE))
                 | (s_req & v_req);

  // A completion only releases the pipeline if the other requester is not waiting.
  assign stallM = reset & stall_c & !((s_ready_c & !v_req) | (v_done_c & !s_req));

  assign vout      = rdata_ld ? load_vec : rdata_q;
  assign v_rdata   = reset ? vout : '0;
  assign v_done    = reset & v_done_c;
  assign s_ready   = reset & s_ready_c;
  assign s_rdata   = reset ? s_rdata_c : '0;
  assign mem_we    = reset & mem_we_c;
  assign mem_addr  = reset ? mem_addr_c : '0;
  assign mem_wdata = reset ? mem_wdata_c : '0;

endmodule

// File: tb/tb_vmem_sequencer.sv
// Bench for vmem_sequencer: word-addressed RAM behind the port, reference
// memory image updated from the access rules, randomized scalar/vector traffic.
module tb_vmem_sequencer;

  localparam int LANES = 8;
  localparam int AW    = 32;
  localparam int VW    = LANES * 32;

  logic          clk;
  logic          reset;
  logic          s_req, s_we;
  logic [AW-1:0] s_addr;
  logic [31:0]   s_wdata, s_rdata;
  logic          s_ready;
  logic          v_req, v_we;
  logic [AW-1:0] v_base;
  logic [VW-1:0] v_wdata, v_rdata;
  logic          v_done, stallM;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_wdata, mem_rdata;

  logic [31:0] ram     [0:1023];
  logic [31:0] exp_mem [0:1023];
  int n_chk;
  int n_pass;

  vmem_sequencer #(.LANES(LANES), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ready(s_ready),
    .v_req(v_req), .v_we(v_we), .v_base(v_base), .v_wdata(v_wdata),
    .v_rdata(v_rdata), .v_done(v_done), .stallM(stallM),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr[11:2]] <= mem_wdata;
    mem_rdata <= ram[mem_addr[11:2]];
  end

  function automatic logic [31:0] beat_ea(input logic [31:0] base, input int i);
    return (base & 32'hFFFF_FFFC) + 32'(4 * i);
  endfunction

  function automatic logic [VW-1:0] exp_vec(input logic [31:0] base);
    logic [VW-1:0] v;
    logic [31:0] ea;
    v = '0;
    for (int i = 0; i < LANES; i++) begin
      ea = beat_ea(base, i);
      v[i*32 +: 32] = exp_mem[ea[11:2]];
    end
    return v;
  endfunction

  task automatic do_swrite(input logic [31:0] a, input logic [31:0] d, output logic rdy,
                           output logic we_o, output logic [31:0] ma, output logic [31:0] md,
                           output logic st);
    s_req = 1'b1; s_we = 1'b1; s_addr = a; s_wdata = d;
    @(negedge clk);
    rdy = s_ready; we_o = mem_we; ma = mem_addr; md = mem_wdata; st = stallM;
    @(posedge clk); #1;
    s_req = 1'b0; s_we = 1'b0;
    exp_mem[a[11:2]] = d;
  endtask

  task automatic do_sread(input logic [31:0] a, output logic [31:0] rd, output int lat,
                          output int nstall, output logic [31:0] ma);
    s_req = 1'b1; s_we = 1'b0; s_addr = a;
    lat = -1; nstall = 0; rd = '0; ma = '0;
    for (int c = 1; c <= 10 && lat < 0; c++) begin
      @(negedge clk);
      if (c == 1) ma = mem_addr;
      if (stallM) nstall++;
      if (s_ready) begin lat = c; rd = s_rdata; end
      @(posedge clk); #1;
    end
    s_req = 1'b0;
  endtask

  task automatic do_vstore(input logic [31:0] base, input logic [VW-1:0] d, output int done,
                           output int nwr, output logic [31:0] first_a, output logic addr_ok,
                           output logic data_ok, output logic stall_ok);
    v_req = 1'b1; v_we = 1'b1; v_base = base; v_wdata = d;
    done = -1; nwr = 0; first_a = '0; addr_ok = 1'b1; data_ok = 1'b1; stall_ok = 1'b1;
    for (int c = 1; c <= 40 && done < 0; c++) begin
      @(negedge clk);
      if (mem_we) begin
        if (nwr >= LANES) addr_ok = 1'b0;
        else begin
          if (nwr == 0) first_a = mem_addr;
          if (mem_addr !== beat_ea(base, nwr)) addr_ok = 1'b0;
          if (mem_wdata !== d[nwr*32 +: 32]) data_ok = 1'b0;
        end
        nwr++;
      end
      if (v_done) done = c;
      if (stallM !== !v_done) stall_ok = 1'b0;
      @(posedge clk); #1;
    end
    v_req = 1'b0; v_we = 1'b0;
    for (int i = 0; i < LANES; i++) exp_mem[beat_ea(base, i) >> 2 & 32'h3FF] = d[i*32 +: 32];
  endtask

  task automatic do_vload(input logic [31:0] base, output int done, output logic [VW-1:0] at_done,
                          output logic [VW-1:0] after, output logic addr_ok);
    v_req = 1'b1; v_we = 1'b0; v_base = base;
    done = -1; at_done = '0; addr_ok = 1'b1;
    for (int c = 1; c <= 40 && done < 0; c++) begin
      @(negedge clk);
      if (c >= 2 && c <= LANES + 1 && mem_addr !== beat_ea(base, c - 2)) addr_ok = 1'b0;
      if (mem_we !== 1'b0) addr_ok = 1'b0;
      if (v_done) begin done = c; at_done = v_rdata; end
      @(posedge clk); #1;
    end
    v_req = 1'b0;
    @(negedge clk);
    after = v_rdata;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    s_req = 1'b1; s_we = 1'b1; s_addr = 32'h40; s_wdata = 32'h1234_5678;
    v_req = 1'b1; v_we = 1'b1; v_base = 32'h100; v_wdata = '1;
    repeat (2) @(negedge clk);
    n_chk++; if ({mem_we, s_ready, v_done, stallM} !== 4'b0) $display("FAIL rst_flags: got %b want 0000", {mem_we, s_ready, v_done, stallM}); else n_pass++;
    n_chk++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) $display("FAIL rst_mem_bus: got addr %h data %h want 0", mem_addr, mem_wdata); else n_pass++;
    n_chk++; if (v_rdata !== '0 || s_rdata !== 32'h0) $display("FAIL rst_rdata: got v %h s %h want 0", v_rdata, s_rdata); else n_pass++;
    s_req = 1'b0; s_we = 1'b0; v_req = 1'b0; v_we = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    n_chk++; if ({stallM, mem_we} !== 2'b00) $display("FAIL rst_release_idle: got %b want 00", {stallM, mem_we}); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_scalar();
    logic rdy, we_o, st;
    logic [31:0] ma, md, rd, a, d;
    int lat, ns;
    do_swrite(32'h40, 32'hDEAD_BEEF, rdy, we_o, ma, md, st);
    n_chk++; if ({rdy, we_o, st} !== 3'b110) $display("FAIL swr_handshake: got rdy/we/stall %b want 110", {rdy, we_o, st}); else n_pass++;
    n_chk++; if (ma !== 32'h40 || md !== 32'hDEAD_BEEF) $display("FAIL swr_bus: got %h/%h want 00000040/deadbeef", ma, md); else n_pass++;
    do_sread(32'h40, rd, lat, ns, ma);
    n_chk++; if (rd !== exp_mem[10'h10]) $display("FAIL srd_data: got %h want %h", rd, exp_mem[10'h10]); else n_pass++;
    n_chk++; if (lat !== 2 || ns !== 1) $display("FAIL srd_timing: got lat %0d stall %0d want 2 1", lat, ns); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      a = 32'($urandom_range(0, 4095)); d = $urandom;
      do_swrite(a, d, rdy, we_o, ma, md, st);
      n_chk++; if (ma !== (a & 32'hFFFF_FFFC) || md !== d) $display("FAIL swr_rand_bus: got %h/%h want %h/%h", ma, md, a & 32'hFFFF_FFFC, d); else n_pass++;
      do_sread(a, rd, lat, ns, ma);
      n_chk++; if (rd !== exp_mem[a[11:2]] || lat !== 2) $display("FAIL srd_rand: got %h lat %0d want %h lat 2", rd, lat, exp_mem[a[11:2]]); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] d, at_done, after;
    logic [31:0] fa;
    logic aok, dok, sok;
    int done, nwr;
    for (int k = 0; k < LANES; k++) d[k*32 +: 32] = 32'h1000 + 32'(k);
    do_vstore(32'h100, d, done, nwr, fa, aok, dok, sok);
    n_chk++; if (done !== 1 + LANES || nwr !== LANES) $display("FAIL vst_timing: got done %0d writes %0d want %0d %0d", done, nwr, 1 + LANES, LANES); else n_pass++;
    n_chk++; if ({aok, dok, sok} !== 3'b111) $display("FAIL vst_beats: got addr/data/stall ok %b want 111", {aok, dok, sok}); else n_pass++;
    do_vload(32'h100, done, at_done, after, aok);
    n_chk++; if (done !== 2 + LANES || !aok) $display("FAIL vld_timing: got done %0d addr_ok %b want %0d 1", done, aok, 2 + LANES); else n_pass++;
    n_chk++; if (at_done !== exp_vec(32'h100)) $display("FAIL vld_data_done: got %h want %h", at_done, exp_vec(32'h100)); else n_pass++;
    n_chk++; if (after !== exp_vec(32'h100)) $display("FAIL vld_data_held: got %h want %h", after, exp_vec(32'h100)); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, ma;
    int lat, ns;
    v_req = 1'b1; v_we = 1'b0; v_base = 32'h100;
    for (int c = 1; c < 5; c++) begin @(negedge clk); @(posedge clk); #1; end
    @(negedge clk);
    n_chk++; if (mem_addr !== 32'h10C) $display("FAIL rmid_beat3_addr: got %h want 0000010c", mem_addr); else n_pass++;
    #1 reset = 1'b0; v_req = 1'b0;
    #1;
    n_chk++; if ({mem_we, s_ready, v_done, stallM} !== 4'b0 || mem_addr !== 32'h0) $display("FAIL rmid_outputs: got flags %b addr %h want 0", {mem_we, s_ready, v_done, stallM}, mem_addr); else n_pass++;
    n_chk++; if (v_rdata !== '0) $display("FAIL rmid_vrdata: got %h want 0", v_rdata); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    n_chk++; if (v_rdata !== '0 || stallM !== 1'b0) $display("FAIL rmid_after_release: got v %h stall %b want 0 0", v_rdata, stallM); else n_pass++;
    @(posedge clk); #1;
    do_sread(32'h40, rd, lat, ns, ma);
    n_chk++; if (rd !== exp_mem[10'h10] || lat !== 2) $display("FAIL rmid_sread: got %h lat %0d want %h lat 2", rd, lat, exp_mem[10'h10]); else n_pass++;
  endtask

  task automatic test_simultaneous();
    logic [VW-1:0] d, at_done, after;
    logic [31:0] sd, rd, ma;
    logic sok, aok;
    int vd, sr, lat, ns;
    for (int k = 0; k < LANES; k++) d[k*32 +: 32] = $urandom;
    sd = $urandom;
    v_req = 1'b1; v_we = 1'b1; v_base = 32'h200; v_wdata = d;
    s_req = 1'b1; s_we = 1'b1; s_addr = 32'h300; s_wdata = sd;
    vd = -1; sr = -1; sok = 1'b1;
    for (int c = 1; c <= 30 && sr < 0; c++) begin
      @(negedge clk);
      if (v_done) vd = c;
      if (s_ready) sr = c;
      if (!s_ready && stallM !== 1'b1) sok = 1'b0;
      @(posedge clk); #1;
      if (vd > 0) begin v_req = 1'b0; v_we = 1'b0; end
    end
    s_req = 1'b0; s_we = 1'b0;
    for (int i = 0; i < LANES; i++) exp_mem[beat_ea(32'h200, i) >> 2 & 32'h3FF] = d[i*32 +: 32];
    exp_mem[10'(32'h300 >> 2)] = sd;
    n_chk++; if (vd !== 1 + LANES || sr !== 2 + LANES) $display("FAIL both_order: got v_done %0d s_ready %0d want %0d %0d", vd, sr, 1 + LANES, 2 + LANES); else n_pass++;
    n_chk++; if (!sok) $display("FAIL both_stall: got a stall gap want continuous"); else n_pass++;
    do_sread(32'h300, rd, lat, ns, ma);
    n_chk++; if (rd !== sd) $display("FAIL both_scalar_data: got %h want %h", rd, sd); else n_pass++;
    do_vload(32'h200, vd, at_done, after, aok);
    n_chk++; if (after !== exp_vec(32'h200)) $display("FAIL both_vector_data: got %h want %h", after, exp_vec(32'h200)); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [VW-1:0] d, at_done, after;
    logic [31:0] fa;
    logic aok, dok, sok;
    int done, nwr;
    for (int k = 0; k < LANES; k++) d[k*32 +: 32] = $urandom;
    do_vstore(32'hFFFF_FFF8, d, done, nwr, fa, aok, dok, sok);
    n_chk++; if (fa !== 32'hFFFF_FFF8 || !aok || nwr !== LANES) $display("FAIL wrap_store_addr: got first %h ok %b n %0d want fffffff8 1 %0d", fa, aok, nwr, LANES); else n_pass++;
    do_vload(32'hFFFF_FFF8, done, at_done, after, aok);
    n_chk++; if (!aok || after !== exp_vec(32'hFFFF_FFF8)) $display("FAIL wrap_load: got ok %b data %h want 1 %h", aok, after, exp_vec(32'hFFFF_FFF8)); else n_pass++;
  endtask

  task automatic test_unaligned();
    logic rdy, we_o, st, aok, dok, sok;
    logic [31:0] ma, md, rd, d, fa;
    logic [VW-1:0] vd, at_done, after;
    int lat, ns, done, nwr;
    d = $urandom;
    do_swrite(32'h43, d, rdy, we_o, ma, md, st);
    n_chk++; if (ma !== 32'h40) $display("FAIL unal_swr_addr: got %h want 00000040", ma); else n_pass++;
    do_sread(32'h41, rd, lat, ns, ma);
    n_chk++; if (ma !== 32'h40 || rd !== d) $display("FAIL unal_srd: got addr %h data %h want 00000040 %h", ma, rd, d); else n_pass++;
    for (int k = 0; k < LANES; k++) vd[k*32 +: 32] = $urandom;
    do_vstore(32'h102, vd, done, nwr, fa, aok, dok, sok);
    n_chk++; if (fa !== 32'h100 || !aok || !dok) $display("FAIL unal_vst: got first %h ok %b%b want 00000100 11", fa, aok, dok); else n_pass++;
    do_vload(32'h102, done, at_done, after, aok);
    n_chk++; if (!aok || after !== exp_vec(32'h100)) $display("FAIL unal_vld: got ok %b data %h want 1 %h", aok, after, exp_vec(32'h100)); else n_pass++;
  endtask

  task automatic test_random();
    logic [VW-1:0] d, at_done, after;
    logic [31:0] base, fa;
    logic aok, dok, sok;
    int done, nwr;
    for (int it = 0; it < 4; it++) begin
      base = 32'($urandom_range(0, 4095));
      for (int k = 0; k < LANES; k++) d[k*32 +: 32] = $urandom;
      do_vstore(base, d, done, nwr, fa, aok, dok, sok);
      n_chk++; if (done !== 1 + LANES || !aok || !dok || !sok) $display("FAIL rand_vst: base %h got done %0d ok %b%b%b want %0d 111", base, done, aok, dok, sok, 1 + LANES); else n_pass++;
      do_vload(base, done, at_done, after, aok);
      n_chk++; if (done !== 2 + LANES || !aok || at_done !== exp_vec(base)) $display("FAIL rand_vld: base %h got done %0d data %h want %0d %h", base, done, at_done, 2 + LANES, exp_vec(base)); else n_pass++;
    end
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    test_reset();
    test_scalar();
    test_back_to_back();
    test_reset_mid();
    test_simultaneous();
    test_wrap();
    test_unaligned();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
